// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with a two-state FSM. It supports zero-gap back-to-back words
// (a new word is accepted during the last bit) and asynchronous abort via clear.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             ready,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             at_end;
  logic             load;

  assign at_end = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
  assign load   = din_valid && ready;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = SHIFT;
      SHIFT:   if (at_end && !load) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Zeros are shifted in behind the data, so the output bit reads 0 once the word has drained.
  always_comb begin
    ready      = (state_q == IDLE) || at_end;
    busy       = (state_q == SHIFT);
    bit_valid  = (state_q == SHIFT);
    last_bit   = at_end;
    serial_out = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
  end

  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (load) begin
      sreg_d = din;
      cnt_d  = '0;
    end else if (state_q == SHIFT) begin
      sreg_d = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
      cnt_d  = at_end ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an MSB-first instance (index 0) and an LSB-first instance (index 1).
// It also includes a downstream 4-bit serial-in register. Expected bits are queued at each offer.
module tb_piso_serializer;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic            clk = 1'b0;
  logic            clear;
  logic [1:0][7:0] din;
  logic [1:0]      dv;
  logic [1:0]      rdy, so, bv, lb, bsy;
  logic [3:0]      ds;

  exp_t q0[$];
  exp_t q1[$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .clear(clear), .din(din[0]), .din_valid(dv[0]), .ready(rdy[0]),
    .serial_out(so[0]), .bit_valid(bv[0]), .last_bit(lb[0]), .busy(bsy[0])
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .clear(clear), .din(din[1]), .din_valid(dv[1]), .ready(rdy[1]),
    .serial_out(so[1]), .bit_valid(bv[1]), .last_bit(lb[1]), .busy(bsy[1])
  );

  // Downstream serial-in shift register; ds[3] is the output stage (oldest bit).
  always @(posedge clk or posedge clear) begin
    if (clear)      ds <= 4'b0;
    else if (bv[0]) ds <= {ds[2:0], so[0]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input int d, input logic [7:0] w);
    exp_t e;
    din[d] = w;
    dv[d]  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e.b    = (d == 0) ? w[7-i] : w[i];
      e.last = (i == 7);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic chk_reset_outputs();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_so%0d", d), so[d], 0);
      chk($sformatf("rst_bv%0d", d), bv[d], 0);
      chk($sformatf("rst_lb%0d", d), lb[d], 0);
      chk($sformatf("rst_busy%0d", d), bsy[d], 0);
      chk($sformatf("rst_rdy%0d", d), rdy[d], 1);
    end
  endtask

  task automatic mon(input int d);
    exp_t e;
    int   qs;
    qs = (d == 0) ? q0.size() : q1.size();
    chk($sformatf("busy_eq_bv%0d", d), bsy[d], bv[d]);
    if (bv[d]) begin
      if (qs == 0) begin
        chk($sformatf("extra_bit%0d", d), bv[d], 0);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("bit%0d", d), so[d], e.b);
        chk($sformatf("last%0d", d), lb[d], e.last);
        chk($sformatf("ready%0d", d), rdy[d], e.last);
      end
    end else begin
      if (qs != 0) chk($sformatf("missing_bit%0d", d), bv[d], 1);
      chk($sformatf("idle_so%0d", d), so[d], 0);
      chk($sformatf("idle_lb%0d", d), lb[d], 0);
      chk($sformatf("idle_rdy%0d", d), rdy[d], 1);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    mon(0);
    mon(1);
  endtask

  task automatic drained();
    chk("drain0", q0.size(), 0);
    chk("drain1", q1.size(), 0);
  endtask

  initial begin
    clear = 1'b1;
    din   = '0;
    dv    = '0;
    #1;
    chk_reset_outputs();
    repeat (2) @(posedge clk);
    #1 clear = 1'b0;
    cyc();
    cyc();

    // Single word A5, MSB first, then idle; downstream register holds last four bits.
    offer(0, 8'hA5);
    cyc();
    dv[0] = 1'b0;
    repeat (7) cyc();
    cyc();
    chk("chain_ds", ds, 4'b0101);
    drained();

    // Back-to-back A5 then 3C with din_valid held through the word.
    offer(0, 8'hA5);
    cyc();
    offer(0, 8'h3C);
    repeat (7) cyc();
    cyc();
    dv[0] = 1'b0;
    repeat (7) cyc();
    cyc();
    drained();

    // Offer of FF while busy must be ignored.
    offer(0, 8'hA5);
    cyc();
    dv[0] = 1'b0;
    cyc();
    din[0] = 8'hFF;
    dv[0]  = 1'b1;
    repeat (4) cyc();
    dv[0] = 1'b0;
    repeat (3) cyc();
    cyc();
    drained();

    // LSB-first instance: A5 then 01.
    offer(1, 8'hA5);
    cyc();
    dv[1] = 1'b0;
    repeat (7) cyc();
    cyc();
    offer(1, 8'h01);
    cyc();
    dv[1] = 1'b0;
    repeat (7) cyc();
    cyc();
    drained();

    // Clear mid-word after three edges; 0F loads on the first edge after release.
    offer(0, 8'hA5);
    cyc();
    dv[0] = 1'b0;
    repeat (3) cyc();
    #3 clear = 1'b1;
    #1;
    chk_reset_outputs();
    q0.delete();
    offer(0, 8'h0F);
    #2 clear = 1'b0;
    cyc();
    dv[0] = 1'b0;
    repeat (7) cyc();
    cyc();
    cyc();
    drained();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
